regfile_wb: RTL
===============

// Module: regfile_wb
// PURPOSE
//   Architectural register file at the write-back end of the pipeline: consumes the
//   (write address, write enable, write data) triple the execute stage produces once it
//   has passed MEM/WB, and serves the decode stage's two operand read ports.
//   Includes a post-reset clearing sequencer and write-to-read bypass so a value being
//   written this cycle is visible to decode in the same cycle.
// PARAMETERS
//   DATA_W  32  register width in bits
//   ADDR_W  5   register address width
//   NREG    32  number of registers (must equal 2**ADDR_W)
// PORTS
//   clk        in   1       clock, all state updates on rising edge
//   rst        in   1       reset, synchronous, active-high
//   we         in   1       write enable from MEM/WB (wreg)
//   waddr      in   ADDR_W  write register address (wd)
//   wdata      in   DATA_W  write data
//   re1        in   1       read port 1 enable
//   raddr1     in   ADDR_W  read port 1 address
//   rdata1     out  DATA_W  read port 1 data (combinational)
//   re2        in   1       read port 2 enable
//   raddr2     in   ADDR_W  read port 2 address
//   rdata2     out  DATA_W  read port 2 data (combinational)
//   init_done  out  1       1 = clearing finished, file accepts writes
//   wr_cnt     out  32      accepted-write counter (only with REGFILE_WR_COUNT_EN)
// BEHAVIOUR
//   - FSM states: INIT, READY. rst=1 at a clock edge -> INIT, clr_cnt=0, init_done=0;
//     applies mid-operation too (any in-progress state discarded, clearing restarts).
//   - INIT: each cycle reg[clr_cnt] <= 0, clr_cnt++. Edge with clr_cnt==NREG-1 clears
//     last reg and moves to READY; init_done=1 from that edge. Total NREG cycles after
//     rst deasserts. we ignored in INIT; rdata1/rdata2 = 0 in INIT.
//   - READY: if we=1 and waddr!=0, reg[waddr] <= wdata at the edge. Writes to reg 0
//     always dropped; reg 0 reads as 0.
//   - Read port n (n=1,2), READY, priority order:
//       ren=0 -> 0; raddrn==0 -> 0; we=1 && waddr==raddrn -> wdata (bypass);
//       else reg[raddrn]. Both ports may hit the same address / bypass simultaneously.
//   - Reads are zero-latency combinational; writes are one-cycle (visible from storage
//     the cycle after the edge, visible via bypass in the write cycle itself).
//   - Reset values: init_done=0, rdata1=rdata2=0, wr_cnt=0; register contents 0 after
//     INIT completes (contents undefined only before the first completed INIT).
//   - No X propagation: out-of-range addresses cannot occur (NREG==2**ADDR_W).
// CONFIGURATION
//   REGFILE_WR_COUNT_EN defined: wr_cnt port present; increments by 1 on every edge
//     in READY where we=1 and waddr!=0; saturates at 32'hFFFF_FFFF; cleared by rst.
//   REGFILE_WR_COUNT_EN undefined: wr_cnt port and counter logic absent; all other
//     behaviour identical.
// TESTING
//   1. rst=1 1 cycle then 0 -> init_done=0 for 32 cycles, 1 on 32nd edge; all 31 regs
//      read 0; we=1 during INIT leaves target reg 0 after INIT.
//   2. READY: write r5=32'hDEAD_BEEF, next cycle re1=1 raddr1=5 -> rdata1=32'hDEAD_BEEF;
//      re1=0 -> rdata1=0.
//   3. Same cycle we=1 waddr=7 wdata=32'h1234_5678, re1=re2=1 raddr1=raddr2=7 ->
//      both rdata=32'h1234_5678 before the edge (bypass).
//   4. we=1 waddr=0 wdata=32'hFFFF_FFFF, re1=1 raddr1=0 same and next cycle -> rdata1=0;
//      wr_cnt unchanged (macro on).
//   5. Write r3=32'hA5A5_A5A5, then rst mid-write stream -> INIT restarts, r3 reads 0
//      after init_done, wr_cnt=0.
//   6. Macro on: 10 writes to r1..r10 -> wr_cnt=10; macro off: build has no wr_cnt port.

Source files
------------

// File: rtl/regfile_wb_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_if
// Brief    : Write-back / operand-read bundle between the pipeline and regfile_wb.
// Revision : 1.0
// ============================================================================
interface regfile_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic              init_done;
`ifdef REGFILE_WR_COUNT_EN
    logic [31:0]       wr_cnt;
`else
    // no accepted-write counter in this build
`endif

    modport master (
        output we, waddr, wdata, re1, raddr1, re2, raddr2,
        input  rdata1, rdata2, init_done
`ifdef REGFILE_WR_COUNT_EN
        , input wr_cnt
`endif
    );

    modport slave (
        input  we, waddr, wdata, re1, raddr1, re2, raddr2,
        output rdata1, rdata2, init_done
`ifdef REGFILE_WR_COUNT_EN
        , output wr_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb
// Brief    : Write-back register file, post-reset clearing sequencer, two
//            bypassed combinational read ports. REGFILE_WR_COUNT_EN adds wr_cnt.
// Revision : 1.0
// ============================================================================
module regfile_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  wire             clk,
    input  wire             rst,
    regfile_wb_if.slave     bus
);

    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(NREG - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_next;
    logic              w_clear_en;
    logic              w_init_done;
    logic              w_wr_en;
    logic [DATA_W-1:0] r_regs [NREG];
    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_INIT;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_clear_en     = 1'b0;
        w_init_done    = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_clear_en     = 1'b1;
                w_clr_cnt_next = r_clr_cnt + ADDR_W'(1);
                if (r_clr_cnt == c_LAST) begin
                    w_state_next = ST_READY;
                end
            end
            ST_READY: begin
                w_init_done = 1'b1;
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    // Register 0 is never a write target; it only ever holds the cleared value.
    assign w_wr_en = w_init_done && bus.we && (bus.waddr != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clear_en) begin
                r_regs[r_clr_cnt] <= '0;
            end else if (w_wr_en) begin
                r_regs[bus.waddr] <= bus.wdata;
            end
        end
    end

    // Bypass compares against raw we/waddr; raddr==0 is already forced to 0 above it.
    always_comb begin
        w_rdata1 = '0;
        if (w_init_done && bus.re1 && (bus.raddr1 != '0)) begin
            if (bus.we && (bus.waddr == bus.raddr1)) begin
                w_rdata1 = bus.wdata;
            end else begin
                w_rdata1 = r_regs[bus.raddr1];
            end
        end
    end

    always_comb begin
        w_rdata2 = '0;
        if (w_init_done && bus.re2 && (bus.raddr2 != '0)) begin
            if (bus.we && (bus.waddr == bus.raddr2)) begin
                w_rdata2 = bus.wdata;
            end else begin
                w_rdata2 = r_regs[bus.raddr2];
            end
        end
    end

    assign bus.rdata1    = w_rdata1;
    assign bus.rdata2    = w_rdata2;
    assign bus.init_done = w_init_done;

`ifdef REGFILE_WR_COUNT_EN
    logic [31:0] r_wr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt <= '0;
        end else if (w_wr_en && (r_wr_cnt != 32'hFFFF_FFFF)) begin
            r_wr_cnt <= r_wr_cnt + 32'd1;
        end
    end

    assign bus.wr_cnt = r_wr_cnt;
`else
    // write counter not built
`endif

endmodule
`default_nettype wire
